i2s_deserializer: RTL and testbench

- I2S receiver: the capture-side counterpart to the I2S serializer.
- Samples serial audio data (ADCDAT) and LRCLK on rising BCLK and reassembles MSB-first words into parallel left/right channel registers.
- Raises per-channel and per-frame valid strobes, and flags short slots.
- Sits between the codec ADC serial pins and downstream parallel audio processing or the loopback serializer.

---
 rtl/i2s_deserializer.sv | 212 +++++++++++++++++++++
 tb/tb_i2s_deserializer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_deserializer.sv
// ---------------------------------------------------------------------------
// i2s_deserializer
//
// I2S capture path. LRCLK and ADCDAT are both sampled as data on the rising
// edge of BCLK. MSB-first words are reassembled into per-channel parallel
// registers. Each register is accompanied by a one-cycle valid strobe. A frame
// strobe fires when a left word and the following right word both complete.
// A slot that ends before a full word has been captured raises a one-cycle
// error strobe.
//
// Ports:
//   BCLK          bit clock, all logic on its rising edge
//   RESET         asynchronous active-high reset
//   LRCLK         word clock, sampled as data on rising BCLK
//   ADCDAT        serial data, sampled on rising BCLK
//   LEFT_CHANNEL  last complete left word
//   RIGHT_CHANNEL last complete right word
//   LEFT_VALID    one-cycle pulse, LEFT_CHANNEL just updated
//   RIGHT_VALID   one-cycle pulse, RIGHT_CHANNEL just updated
//   FRAME_VALID   one-cycle pulse, left then right word of a frame completed
//   SLOT_ERR      one-cycle pulse, slot ended before DATA_WIDTH bits arrived
// ---------------------------------------------------------------------------
module i2s_deserializer #(
    parameter int   DATA_WIDTH = 16,
    parameter logic LEFT_LEVEL = 1'b1
) (
    input  logic                  BCLK,
    input  logic                  RESET,
    input  logic                  LRCLK,
    input  logic                  ADCDAT,
    output logic [DATA_WIDTH-1:0] LEFT_CHANNEL,
    output logic [DATA_WIDTH-1:0] RIGHT_CHANNEL,
    output logic                  LEFT_VALID,
    output logic                  RIGHT_VALID,
    output logic                  FRAME_VALID,
    output logic                  SLOT_ERR
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        PRIME,
        SYNC,
        SHIFT,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  lr_d;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  slot_left;
    logic                  slot_left_next;
    logic                  left_done;
    logic                  left_done_next;
    logic [DATA_WIDTH-1:0] left_next;
    logic [DATA_WIDTH-1:0] right_next;
    logic                  left_valid_next;
    logic                  right_valid_next;
    logic                  frame_valid_next;
    logic                  slot_err_next;

    logic                  lr_edge;
    logic                  new_is_left;
    logic [DATA_WIDTH-1:0] word;
    logic                  do_start;
    logic                  do_shift;
    logic                  do_complete;
    logic                  do_error;

    // An LRCLK transition only counts once lr_d holds a real sample, i.e.
    // after the PRIME cycle. The word being assembled always includes the
    // bit sampled on this very edge so the LSB can land on a slot boundary.
    assign lr_edge     = (state != PRIME) && (LRCLK != lr_d);
    assign new_is_left = (LRCLK == LEFT_LEVEL);
    assign word        = {shift_reg[DATA_WIDTH-2:0], ADCDAT};

    // Next-state decode. The state machine only decides which actions happen
    // this cycle (start a slot, shift, complete a word, flag a short slot);
    // the actions are then applied uniformly below so that a completion and
    // a slot restart can coincide on back-to-back full-length slots.
    always_comb begin
        state_next       = state;
        do_start         = 1'b0;
        do_shift         = 1'b0;
        do_complete      = 1'b0;
        do_error         = 1'b0;

        case (state)
            PRIME: begin
                state_next = SYNC;
            end
            SYNC: begin
                if (lr_edge) begin
                    do_start = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    do_complete = 1'b1;
                    if (lr_edge) begin
                        do_start = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end else if (lr_edge) begin
                    do_error = 1'b1;
                    do_start = 1'b1;
                end else begin
                    do_shift = 1'b1;
                end
            end
            DONE: begin
                if (lr_edge) begin
                    do_start = 1'b1;
                end
            end
            default: begin
                state_next = SYNC;
            end
        endcase

        if (do_start) begin
            state_next = SHIFT;
        end
    end

    // Datapath updates driven by the actions chosen above. Strobes default to
    // zero every cycle so none of them can ever last longer than one BCLK.
    // A short slot clears left_done so a frame strobe always needs a clean
    // left word followed directly by a clean right word.
    always_comb begin
        bit_cnt_next     = bit_cnt;
        shift_next       = shift_reg;
        slot_left_next   = slot_left;
        left_done_next   = left_done;
        left_next        = LEFT_CHANNEL;
        right_next       = RIGHT_CHANNEL;
        left_valid_next  = 1'b0;
        right_valid_next = 1'b0;
        frame_valid_next = 1'b0;
        slot_err_next    = 1'b0;

        if (do_shift) begin
            shift_next   = word;
            bit_cnt_next = bit_cnt + 1'b1;
        end

        if (do_complete) begin
            if (slot_left) begin
                left_next       = word;
                left_valid_next = 1'b1;
                left_done_next  = 1'b1;
            end else begin
                right_next       = word;
                right_valid_next = 1'b1;
                if (left_done) begin
                    frame_valid_next = 1'b1;
                end
                left_done_next = 1'b0;
            end
        end

        if (do_error) begin
            slot_err_next  = 1'b1;
            left_done_next = 1'b0;
        end

        if (do_start) begin
            bit_cnt_next   = '0;
            shift_next     = '0;
            slot_left_next = new_is_left;
        end
    end

    // State register and all registered outputs. Reset may arrive at any
    // point, including mid-slot, and forces a fresh PRIME/SYNC sequence.
    always_ff @(posedge BCLK or posedge RESET) begin
        if (RESET) begin
            state         <= PRIME;
            lr_d          <= 1'b0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            slot_left     <= 1'b0;
            left_done     <= 1'b0;
            LEFT_CHANNEL  <= '0;
            RIGHT_CHANNEL <= '0;
            LEFT_VALID    <= 1'b0;
            RIGHT_VALID   <= 1'b0;
            FRAME_VALID   <= 1'b0;
            SLOT_ERR      <= 1'b0;
        end else begin
            state         <= state_next;
            lr_d          <= LRCLK;
            bit_cnt       <= bit_cnt_next;
            shift_reg     <= shift_next;
            slot_left     <= slot_left_next;
            left_done     <= left_done_next;
            LEFT_CHANNEL  <= left_next;
            RIGHT_CHANNEL <= right_next;
            LEFT_VALID    <= left_valid_next;
            RIGHT_VALID   <= right_valid_next;
            FRAME_VALID   <= frame_valid_next;
            SLOT_ERR      <= slot_err_next;
        end
    end

endmodule

// File: tb/tb_i2s_deserializer.sv
// ---------------------------------------------------------------------------
// tb_i2s_deserializer
//
// Drives an I2S stream slot by slot into two receivers: one with the default
// LEFT_LEVEL=1 and one built with LEFT_LEVEL=0. For the default receiver, a
// slot-level model pushes the expected strobe events into a queue. Each event
// carries the posedge index at which it must appear. The queue is popped and
// compared as the receiver produces output. The second receiver is checked
// directly to confirm its channel mapping.
// ---------------------------------------------------------------------------
module tb_i2s_deserializer;

    localparam int DW = 16;

    logic          BCLK = 1'b0;
    logic          RESET;
    logic          LRCLK;
    logic          ADCDAT;
    logic [DW-1:0] left_channel;
    logic [DW-1:0] right_channel;
    logic          left_valid;
    logic          right_valid;
    logic          frame_valid;
    logic          slot_err;
    logic [DW-1:0] left_channel_b;
    logic [DW-1:0] right_channel_b;
    logic          left_valid_b;
    logic          right_valid_b;
    logic          frame_valid_b;
    logic          slot_err_b;

    i2s_deserializer #(.DATA_WIDTH(DW), .LEFT_LEVEL(1'b1)) dut (
        .BCLK          (BCLK),
        .RESET         (RESET),
        .LRCLK         (LRCLK),
        .ADCDAT        (ADCDAT),
        .LEFT_CHANNEL  (left_channel),
        .RIGHT_CHANNEL (right_channel),
        .LEFT_VALID    (left_valid),
        .RIGHT_VALID   (right_valid),
        .FRAME_VALID   (frame_valid),
        .SLOT_ERR      (slot_err)
    );

    i2s_deserializer #(.DATA_WIDTH(DW), .LEFT_LEVEL(1'b0)) dut_b (
        .BCLK          (BCLK),
        .RESET         (RESET),
        .LRCLK         (LRCLK),
        .ADCDAT        (ADCDAT),
        .LEFT_CHANNEL  (left_channel_b),
        .RIGHT_CHANNEL (right_channel_b),
        .LEFT_VALID    (left_valid_b),
        .RIGHT_VALID   (right_valid_b),
        .FRAME_VALID   (frame_valid_b),
        .SLOT_ERR      (slot_err_b)
    );

    // Free-running bit clock.
    always #5 BCLK = ~BCLK;

    // Index of the most recent rising BCLK edge.
    int cyc = 0;
    always @(posedge BCLK) begin
        cyc <= cyc + 1;
    end

    typedef struct {
        int            cyc;
        logic [3:0]    strobes;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } ev_t;

    ev_t           sb[$];
    int            checks   = 0;
    int            failures = 0;

    logic          capturing;
    int            prev_len;
    logic          left_done_m;
    logic [DW-1:0] exp_left;
    logic [DW-1:0] exp_right;
    logic          pend;

    function automatic logic bitAt(input logic [DW-1:0] w, input int k);
        if (k < DW) begin
            return w[DW-1-k];
        end
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pushEvent(input int at, input logic [3:0] st);
        ev_t e;
        e.cyc     = at;
        e.strobes = st;
        e.l       = exp_left;
        e.r       = exp_right;
        sb.push_back(e);
    endtask

    // Called once per BCLK just after the falling edge: either the head of
    // the scoreboard is due and is compared in full, or all strobes must be low.
    task automatic checkOutput();
        logic [3:0] obs;
        ev_t        e;
        obs = {left_valid, right_valid, frame_valid, slot_err};
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            expectEq("event_cycle", 32'(cyc), 32'(e.cyc));
            expectEq("strobes_lv_rv_fv_se", {28'd0, obs}, {28'd0, e.strobes});
            expectEq("left_channel", {16'd0, left_channel}, {16'd0, e.l});
            expectEq("right_channel", {16'd0, right_channel}, {16'd0, e.r});
        end else begin
            expectEq("idle_strobes", {28'd0, obs}, 32'd0);
        end
    endtask

    task automatic applyStimulus(input logic lr, input logic d);
        @(negedge BCLK);
        checkOutput();
        LRCLK  = lr;
        ADCDAT = d;
    endtask

    task automatic driveIdle(input logic lr, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(lr, 1'($urandom_range(1, 0)));
        end
    endtask

    // One slot at level lr. The first cycle carries the last bit of the
    // previous slot (one-BCLK I2S delay), then the word MSB first, then
    // random padding for slots longer than DW.
    task automatic driveSlot(input logic lr, input logic [DW-1:0] w, input int len);
        int p0;
        applyStimulus(lr, pend);
        p0 = cyc + 1;
        if (capturing && prev_len < DW) begin
            left_done_m = 1'b0;
            pushEvent(p0, 4'b0001);
        end
        capturing = 1'b1;
        if (len >= DW) begin
            if (lr == 1'b1) begin
                exp_left    = w;
                left_done_m = 1'b1;
                pushEvent(p0 + DW, 4'b1000);
            end else begin
                exp_right = w;
                pushEvent(p0 + DW, {1'b0, 1'b1, left_done_m, 1'b0});
                left_done_m = 1'b0;
            end
        end
        prev_len = len;
        for (int j = 1; j < len; j++) begin
            applyStimulus(lr, bitAt(w, j - 1));
        end
        pend = bitAt(w, len - 1);
    endtask

    task automatic checkAllZero(input string tag);
        expectEq({tag, "_left_channel"}, {16'd0, left_channel}, 32'd0);
        expectEq({tag, "_right_channel"}, {16'd0, right_channel}, 32'd0);
        expectEq({tag, "_strobes"}, {28'd0, left_valid, right_valid, frame_valid, slot_err}, 32'd0);
        expectEq({tag, "_b_channels"}, {left_channel_b, right_channel_b}, 32'd0);
    endtask

    task automatic modelReset();
        capturing   = 1'b0;
        prev_len    = DW;
        left_done_m = 1'b0;
        exp_left    = '0;
        exp_right   = '0;
    endtask

    // Directed sequence: reset, long slots, back-to-back slots, a short slot,
    // an asynchronous reset in the middle of a word, a release mid-slot, and
    // the inverted LEFT_LEVEL mapping.
    initial begin
        RESET  = 1'b1;
        LRCLK  = 1'b0;
        ADCDAT = 1'b0;
        pend   = 1'b0;
        modelReset();

        #2;
        checkAllZero("reset");
        repeat (2) @(negedge BCLK);
        applyStimulus(1'b0, 1'b0);
        RESET = 1'b0;
        driveIdle(1'b0, 5);

        $display("[TB] standard 32-BCLK frame");
        driveSlot(1'b1, 16'hA5C3, 32);
        driveSlot(1'b0, 16'h1234, 32);

        $display("[TB] back-to-back 16-BCLK frames");
        for (int f = 0; f < 4; f++) begin
            driveSlot(1'b1, 16'hFFFF, 16);
            driveSlot(1'b0, 16'h0001, 16);
        end

        $display("[TB] short right slot then recovery");
        driveSlot(1'b1, 16'hBEEF, 16);
        driveSlot(1'b0, 16'h5555, 10);
        driveSlot(1'b1, 16'h0F0F, 16);
        driveSlot(1'b0, 16'hF0F0, 16);
        driveSlot(1'b1, 16'h3C3C, 32);

        $display("[TB] asynchronous reset mid right word");
        driveSlot(1'b0, 16'h7777, 8);
        @(posedge BCLK);
        #2;
        RESET = 1'b1;
        #1;
        checkAllZero("async_reset");
        modelReset();
        expectEq("queue_empty_at_reset", 32'(sb.size()), 32'd0);
        sb.delete();
        driveIdle(1'b1, 3);
        applyStimulus(1'b1, 1'($urandom_range(1, 0)));
        RESET = 1'b0;
        driveIdle(1'b1, 7);

        $display("[TB] resync after release mid left slot");
        driveSlot(1'b0, 16'h2468, 16);
        driveSlot(1'b1, 16'h9ABC, 16);
        driveSlot(1'b0, 16'h1111, 16);
        driveSlot(1'b1, 16'h55AA, 32);

        $display("[TB] LEFT_LEVEL=0 mapping");
        driveSlot(1'b0, 16'h8001, 16);
        driveSlot(1'b1, 16'h4321, 16);
        expectEq("b_left_is_low_slot", {16'd0, left_channel_b}, 32'h8001);
        expectEq("b_right_keeps_high_slot", {16'd0, right_channel_b}, 32'h55AA);
        driveSlot(1'b0, 16'hC0DE, 32);
        expectEq("b_right_after_high", {16'd0, right_channel_b}, 32'h4321);
        expectEq("b_left_after_low", {16'd0, left_channel_b}, 32'hC0DE);
        driveIdle(1'b0, 8);

        expectEq("queue_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
